// File: rtl/mdu_arbiter.sv
// Shares one multiplier and one iterative divider between the two EX issue pipes.
// Pipe c (older) is always served before pipe p; results are written to HI/LO.
module mdu_arbiter #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        c_req,
  input  logic [1:0]  c_op,
  input  logic [31:0] c_a,
  input  logic [31:0] c_b,
  input  logic        p_req,
  input  logic [1:0]  p_op,
  input  logic [31:0] p_a,
  input  logic [31:0] p_b,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        c_stall_req,
  output logic        p_stall_req
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2,
    WB       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_done_q, c_done_d;
  logic             p_done_q, p_done_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [63:0]      res_q, res_d;

  logic        c_pend, p_pend, sel_p, idle_go, sel_b_zero, div_zero, ex_adv;
  logic [1:0]  sel_op;
  logic [31:0] sel_a, sel_b;

  // Request selection: c always wins while it still has an op outstanding.
  always_comb begin
    c_pend     = c_req & ~c_done_q;
    p_pend     = p_req & ~p_done_q & ~c_pend;
    sel_p      = ~c_pend;
    sel_op     = sel_p ? p_op : c_op;
    sel_a      = sel_p ? p_a  : c_a;
    sel_b      = sel_p ? p_b  : c_b;
    sel_b_zero = (sel_b == 32'd0);
    idle_go    = (state_q == IDLE) & (c_pend | p_pend) & ~flush;
  end

  assign mul_start  = idle_go & ~sel_op[1];
  assign div_start  = idle_go &  sel_op[1] & ~sel_b_zero;
  assign div_zero   = idle_go &  sel_op[1] &  sel_b_zero;

  assign mul_signed = mul_start ? ~sel_op[0] : ((state_q == MUL_BUSY) & sgn_q);
  assign mul_a      = mul_start ? sel_a : ((state_q == MUL_BUSY) ? a_q : 32'd0);
  assign mul_b      = mul_start ? sel_b : ((state_q == MUL_BUSY) ? b_q : 32'd0);
  assign div_signed = div_start ? ~sel_op[0] : ((state_q == DIV_BUSY) & sgn_q);
  assign div_a      = div_start ? sel_a : ((state_q == DIV_BUSY) ? a_q : 32'd0);
  assign div_b      = div_start ? sel_b : ((state_q == DIV_BUSY) ? b_q : 32'd0);
  assign div_cancel = flush & (state_q == DIV_BUSY);

  assign hilo_we    = (state_q == WB) & ~flush;
  assign hi_wdata   = hilo_we ? res_q[63:32] : 32'd0;
  assign lo_wdata   = hilo_we ? res_q[31:0]  : 32'd0;

  // A pipe's stall drops in its own write-back cycle so EX can advance there.
  assign c_stall_req = c_req & ~c_done_q & ~((state_q == WB) & ~owner_q);
  assign p_stall_req = p_req & ~p_done_q & ~((state_q == WB) &  owner_q);
  assign ex_adv      = ~ex_stall & ~c_stall_req & ~p_stall_req;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    c_done_d = c_done_q;
    p_done_d = p_done_q;
    sgn_d    = sgn_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    unique case (state_q)
      IDLE: begin
        if (mul_start | div_start) begin
          owner_d = sel_p;
          sgn_d   = ~sel_op[0];
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = mul_start ? MUL_BUSY : DIV_BUSY;
          cnt_d   = mul_start ? CNT_W'(1) : '0;
        end else if (div_zero) begin
          if (sel_p) p_done_d = 1'b1;
          else       c_done_d = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          res_d   = mul_result;
          cnt_d   = '0;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV_BUSY: begin
        if (div_done) begin
          res_d   = {div_r, div_q};
          state_d = WB;
        end
      end
      WB: begin
        if (owner_q) p_done_d = 1'b1;
        else         c_done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // EX advancing retires both slots; a new instruction must not inherit a done flag.
    if (ex_adv) begin
      c_done_d = 1'b0;
      p_done_d = 1'b0;
    end
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      c_done_d = 1'b0;
      p_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      c_done_q <= 1'b0;
      p_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      c_done_q <= c_done_d;
      p_done_q <= p_done_d;
    end
  end

  // Operand and result holding registers; outputs are gated by state, so no reset needed.
  always_ff @(posedge clk) begin
    sgn_q <= sgn_d;
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
  end

endmodule

// File: tb/tb_mdu_arbiter.sv
// Bench for mdu_arbiter: directed scenarios with literal expectations, then randomized
// pipeline traffic checked every cycle against a transaction-level reference model.
module tb_mdu_arbiter;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn, flush, ex_stall, c_req, p_req;
  logic [1:0]  c_op, p_op;
  logic [31:0] c_a, c_b, p_a, p_b;
  logic        mul_start, mul_signed, div_start, div_cancel, div_signed, div_done, hilo_we;
  logic [31:0] mul_a, mul_b, div_a, div_b, div_q, div_r, hi_wdata, lo_wdata;
  logic [63:0] mul_result;
  logic        c_stall_req, p_stall_req;

  mdu_arbiter #(.MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .ex_stall(ex_stall),
    .c_req(c_req), .c_op(c_op), .c_a(c_a), .c_b(c_b),
    .p_req(p_req), .p_op(p_op), .p_a(p_a), .p_b(p_b),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result),
    .div_start(div_start), .div_cancel(div_cancel), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .c_stall_req(c_stall_req), .p_stall_req(p_stall_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one job record with a predicted write-back cycle.
  bit          m_active, m_owner, m_is_div, m_cdone, m_pdone;
  int          m_wb = -1;
  logic [63:0] m_res;
  bit          e_wb, e_mstart, e_dstart, e_div0, e_cancel, e_we, e_cst, e_pst, e_adv;
  bit          e_sel, e_isdiv, e_sgn;
  logic [31:0] e_a, e_b;

  // External unit models.
  bit          mr_busy, dr_busy;
  int          mr_due, dr_due;
  logic [63:0] mr_prod;
  logic [31:0] dr_q, dr_r;
  int          div_lat = 5;
  bit          honor_cancel = 1'b1;

  // Per-scenario logs of what the DUT did.
  int          t0, n_ms, n_ds, n_dc, n_we, ms_cyc, dc_cyc;
  int          we_cyc [4];
  logic [31:0] we_hi [4];
  logic [31:0] we_lo [4];
  logic [31:0] cst_mask, pst_mask;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] mulf(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [63:0] xa, xb;
    xa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    return xa * xb;
  endfunction

  function automatic logic [63:0] divf(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'h0;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    if (sgn) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  task automatic model_eval();
    bit c_pend, p_pend, go;
    logic [1:0] op;
    c_pend   = c_req && !m_cdone;
    p_pend   = p_req && !m_pdone && !c_pend;
    e_wb     = m_active && (m_wb == cyc);
    go       = !m_active && !flush && (c_pend || p_pend);
    e_sel    = !c_pend;
    op       = e_sel ? p_op : c_op;
    e_a      = e_sel ? p_a : c_a;
    e_b      = e_sel ? p_b : c_b;
    e_isdiv  = op[1];
    e_sgn    = !op[0];
    e_mstart = go && !op[1];
    e_dstart = go && op[1] && (e_b != 32'd0);
    e_div0   = go && op[1] && (e_b == 32'd0);
    e_cancel = flush && m_active && m_is_div && !e_wb;
    e_we     = e_wb && !flush;
    e_cst    = c_req && !m_cdone && !(e_wb && !m_owner);
    e_pst    = p_req && !m_pdone && !(e_wb && m_owner);
    e_adv    = !ex_stall && !e_cst && !e_pst;
  endtask

  task automatic model_update();
    if (!resetn) begin
      m_active = 0; m_cdone = 0; m_pdone = 0; m_wb = -1; mr_busy = 0; dr_busy = 0;
      return;
    end
    if (flush) begin
      m_active = 0; m_cdone = 0; m_pdone = 0;
      return;
    end
    if (e_wb) begin
      if (m_owner) m_pdone = 1; else m_cdone = 1;
      m_active = 0;
    end else if (m_active && m_is_div && m_wb < 0 && div_done) begin
      m_wb = cyc + 1;
    end
    if (e_mstart || e_dstart) begin
      m_active = 1;
      m_owner  = e_sel;
      m_is_div = e_isdiv;
      m_res    = e_isdiv ? divf(e_a, e_b, e_sgn) : mulf(e_a, e_b, e_sgn);
      m_wb     = e_isdiv ? -1 : cyc + MUL_LAT + 1;
    end
    if (e_div0) begin
      if (e_sel) m_pdone = 1; else m_cdone = 1;
    end
    if (e_adv) begin
      m_cdone = 0; m_pdone = 0;
    end
  endtask

  task automatic check_cycle();
    int rel;
    rel = cyc - t0;
    if (div_cancel) begin n_dc++; dc_cyc = rel; end
    if (!resetn) begin
      chk("reset_ctrl", {88'h0, mul_start, mul_signed, div_start, div_cancel, div_signed, hilo_we,
                         c_stall_req, p_stall_req}, 96'h0);
      chk("reset_data", {64'h0, mul_a | mul_b | div_a | div_b | hi_wdata | lo_wdata}, 96'h0);
      return;
    end
    model_eval();
    chk("ctrl", {90'h0, mul_start, div_start, div_cancel, hilo_we, c_stall_req, p_stall_req},
        {90'h0, e_mstart, e_dstart, e_cancel, e_we, e_cst, e_pst});
    if (e_we) chk("hilo_data", {32'h0, hi_wdata, lo_wdata}, {32'h0, m_res});
    if (e_mstart) chk("mul_opnd", {31'h0, mul_signed, mul_a, mul_b}, {31'h0, e_sgn, e_a, e_b});
    if (e_dstart) chk("div_opnd", {31'h0, div_signed, div_a, div_b}, {31'h0, e_sgn, e_a, e_b});
    if (mul_start) begin n_ms++; ms_cyc = rel; end
    if (div_start) n_ds++;
    if (hilo_we) begin
      if (n_we < 4) begin we_cyc[n_we] = rel; we_hi[n_we] = hi_wdata; we_lo[n_we] = lo_wdata; end
      n_we++;
    end
    if (rel >= 0 && rel < 32) begin
      if (c_stall_req) cst_mask[rel] = 1'b1;
      if (p_stall_req) pst_mask[rel] = 1'b1;
    end
    if (mul_start) begin
      mr_busy = 1; mr_due = cyc + MUL_LAT; mr_prod = mulf(mul_a, mul_b, mul_signed);
    end
    if (div_cancel && honor_cancel) dr_busy = 0;
    if (div_start) begin
      dr_busy = 1; dr_due = cyc + div_lat;
      {dr_r, dr_q} = divf(div_a, div_b, div_signed);
    end
  endtask

  task automatic drive_units();
    if (mr_busy && mr_due == cyc) begin
      mul_result = mr_prod; mr_busy = 0;
    end else begin
      mul_result = {$urandom, $urandom};
    end
    if (dr_busy && dr_due == cyc) begin
      div_done = 1'b1; div_q = dr_q; div_r = dr_r; dr_busy = 0;
    end else begin
      div_done = 1'b0; div_q = $urandom; div_r = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    drive_units();
  endtask

  task automatic begin_test();
    t0 = cyc; n_ms = 0; n_ds = 0; n_dc = 0; n_we = 0; ms_cyc = -1; dc_cyc = -1;
    cst_mask = '0; pst_mask = '0;
    for (int i = 0; i < 4; i++) begin we_cyc[i] = -1; we_hi[i] = '0; we_lo[i] = '0; end
  endtask

  task automatic idle_inputs();
    c_req = 0; p_req = 0; flush = 0; ex_stall = 0;
    c_op = 0; p_op = 0; c_a = 0; c_b = 0; p_a = 0; p_b = 0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(3) == 0) r = 32'($urandom_range(15)) - 32'd8;
    return r;
  endfunction

  initial begin
    bit adv_prev;
    idle_inputs();
    mul_result = '0; div_done = 0; div_q = '0; div_r = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    begin_test();
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Signed MULT with operand changes after start.
    begin_test();
    c_req = 1; c_op = 2'b00; c_a = 32'hFFFF_FFFF; c_b = 32'd2;
    tick();
    c_a = 32'h1234_5678; c_b = 32'd9;
    tick(); tick(); tick();
    c_req = 0; tick(); tick();
    chk("t1_mulstart_cnt", 96'(n_ms), 96'd1);
    chk("t1_mulstart_cyc", 96'(ms_cyc), 96'd0);
    chk("t1_we_cyc", 96'(we_cyc[0]), 96'd3);
    chk("t1_we_cnt", 96'(n_we), 96'd1);
    chk("t1_hilo", {32'h0, we_hi[0], we_lo[0]}, {32'h0, 64'hFFFF_FFFF_FFFF_FFFE});
    chk("t1_cstall", 96'(cst_mask), 96'h7);

    // Unsigned MULTU, same operands.
    begin_test();
    c_req = 1; c_op = 2'b01; c_a = 32'hFFFF_FFFF; c_b = 32'd2;
    repeat (4) tick();
    c_req = 0; tick(); tick();
    chk("t2_hilo", {32'h0, we_hi[0], we_lo[0]}, {32'h0, 64'h0000_0001_FFFF_FFFE});

    // c DIV -7/2 and p DIVU 9/4 issued together.
    begin_test();
    div_lat = 5;
    c_req = 1; c_op = 2'b10; c_a = 32'hFFFF_FFF9; c_b = 32'd2;
    p_req = 1; p_op = 2'b11; p_a = 32'd9; p_b = 32'd4;
    repeat (14) tick();
    c_req = 0; p_req = 0; tick(); tick();
    chk("t3_we_cnt", 96'(n_we), 96'd2);
    chk("t3_c_hilo", {32'h0, we_hi[0], we_lo[0]}, {32'h0, 64'hFFFF_FFFF_FFFF_FFFD});
    chk("t3_p_hilo", {32'h0, we_hi[1], we_lo[1]}, {32'h0, 64'h0000_0001_0000_0002});
    chk("t3_we_cycs", {32'h0, 32'(we_cyc[0]), 32'(we_cyc[1])}, {32'h0, 32'd6, 32'd13});
    chk("t3_pstall", 96'(pst_mask), 96'h1FFF);
    chk("t3_cstall", 96'(cst_mask), 96'h3F);

    // Divide by zero completes in one cycle without touching the divider.
    begin_test();
    c_req = 1; c_op = 2'b10; c_a = 32'd5; c_b = 32'd0;
    tick(); tick();
    c_req = 0; tick(); tick();
    chk("t4_divstart_cnt", 96'(n_ds), 96'd0);
    chk("t4_we_cnt", 96'(n_we), 96'd0);
    chk("t4_cstall", 96'(cst_mask), 96'h1);

    // Flush during DIV_BUSY; the divider still answers late.
    begin_test();
    honor_cancel = 0;
    c_req = 1; c_op = 2'b11; c_a = 32'd100; c_b = 32'd7;
    tick(); tick();
    flush = 1; tick();
    flush = 0; c_req = 0;
    repeat (6) tick();
    honor_cancel = 1;
    chk("t5_divstart_cnt", 96'(n_ds), 96'd1);
    chk("t5_cancel", {32'h0, 32'(n_dc), 32'(dc_cyc)}, {32'h0, 32'd1, 32'd2});
    chk("t5_we_cnt", 96'(n_we), 96'd0);

    // EX held for several cycles after write-back: the op must not re-execute.
    begin_test();
    c_req = 1; c_op = 2'b00; c_a = 32'd3; c_b = 32'd5;
    repeat (3) tick();
    ex_stall = 1; repeat (5) tick();
    ex_stall = 0; tick();
    c_req = 0; tick(); tick();
    chk("t6_mulstart_cnt", 96'(n_ms), 96'd1);
    chk("t6_we", {32'h0, 32'(n_we), 32'(we_cyc[0])}, {32'h0, 32'd1, 32'd3});
    chk("t6_hilo", {32'h0, we_hi[0], we_lo[0]}, {32'h0, 64'd15});
    chk("t6_cstall", 96'(cst_mask), 96'h7);

    // Reset in the middle of a divide.
    begin_test();
    c_req = 1; c_op = 2'b10; c_a = 32'd50; c_b = 32'd3;
    tick(); tick();
    resetn = 0; c_req = 0;
    tick(); tick();
    resetn = 1;
    repeat (8) tick();
    chk("t7_cancel_cnt", 96'(n_dc), 96'd0);
    chk("t7_we_cnt", 96'(n_we), 96'd0);

    // Randomized pipeline traffic.
    begin_test();
    adv_prev = 1;
    for (int n = 0; n < 4000; n++) begin
      if (adv_prev || flush) begin
        c_req = ($urandom_range(1) == 0);
        p_req = ($urandom_range(2) != 0);
        c_op = 2'($urandom); p_op = 2'($urandom);
        c_a = rnd_opnd(); c_b = rnd_opnd(); p_a = rnd_opnd(); p_b = rnd_opnd();
        if ($urandom_range(7) == 0) c_b = 32'd0;
        if ($urandom_range(7) == 0) p_b = 32'd0;
      end
      ex_stall = ($urandom_range(3) == 0);
      flush    = ($urandom_range(39) == 0);
      div_lat  = 1 + $urandom_range(6);
      tick();
      adv_prev = e_adv;
    end
    idle_inputs();
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
